instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 28 ++
 rtl/instr_sequencer_if.sv | 25 ++
 rtl/instr_sequencer_prog_mem.sv | 35 +++
 rtl/instr_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// Instruction format: 22-bit word, opcode in the low nibble.
package instr_sequencer_pkg;

    localparam int IW     = 22;
    localparam int OP_LSB = 0;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_END  = 4'b0000;
    localparam logic [OP_W-1:0] OP_LOAD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUM  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    function automatic logic [OP_W-1:0] opcode(input logic [IW-1:0] w);
        return w[OP_LSB +: OP_W];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Valid/ready link between the sequencer and its coprocessor,
// plus the coprocessor's completion pulse.
interface instr_sequencer_if;
    import instr_sequencer_pkg::*;

    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          cop_ready;
    logic          cop_done;

    modport master (
        output instr,
        output instr_valid,
        input  cop_ready,
        input  cop_done
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output cop_ready,
        output cop_done
    );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: synchronous write, synchronous registered read.
// Only the read register is reset; stored contents survive reset.
module seq_prog_mem
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: runs a stored program, handing each word to a
// coprocessor and waiting for its completion pulse before moving on.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [IW-1:0]     prog_data,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              abort,
    instr_sequencer_if.master cop,
    output logic [AW-1:0]     pc,
    output logic              busy,
    output logic              finished,
    output logic              error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] pc_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          err_nx;
    logic          fetch;
    logic          valid;
    logic          fin;
    logic          mem_we;
    logic          op_end;
    logic          last;
    logic [IW-1:0] word;

    assign mem_we = prog_we && (state == S_IDLE);

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (fetch),
        .raddr (pc),
        .rdata (word)
    );

    assign op_end = (opcode(word) == OP_END);
    assign last   = (pc == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            cnt   <= cnt_nx;
            error <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        err_nx   = error;
        fetch    = 1'b0;
        valid    = 1'b0;
        fin      = 1'b0;
        // abort outranks every same-cycle handshake or step event
        if (abort && (state != S_IDLE)) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_FETCH;
                        pc_nx    = '0;
                        err_nx   = 1'b0;
                    end
                end
                S_FETCH: begin
                    fetch    = 1'b1;
                    state_nx = S_ISSUE;
                end
                S_ISSUE: begin
                    if (op_end) begin
                        state_nx = S_DONE;
                    end else begin
                        valid = 1'b1;
                        if (cop.cop_ready) begin
                            state_nx = S_WAIT;
                            cnt_nx   = '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (cop.cop_done) begin
                        cnt_nx = '0;
                        if (last) begin
                            state_nx = S_DONE;
                        end else begin
                            pc_nx    = pc + AW'(1);
                            state_nx = step_mode ? S_PAUSE : S_FETCH;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state_nx = S_ERROR;
                        err_nx   = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                S_PAUSE: begin
                    if (step) begin
                        state_nx = S_FETCH;
                    end
                end
                S_DONE: begin
                    fin      = 1'b1;
                    state_nx = S_IDLE;
                end
                S_ERROR: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign cop.instr       = word;
    assign cop.instr_valid = valid;
    assign finished        = fin;
    assign busy            = (state != S_IDLE);

endmodule
